aer_receiver: RTL and testbench

AER_RECEIVER -- requirements
Module: aer_receiver

---
 rtl/tinyodin_aer_pkg.sv | 24 ++
 rtl/aer_rx_fifo.sv | 65 ++++++
 rtl/aer_receiver.sv | 115 +++++++++++
 tb/tb_aer_receiver.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/tinyodin_aer_pkg.sv
// Shared types for the AER receiver: event-type encoding and handshake FSM states.
package tinyodin_aer_pkg;

    typedef enum logic [1:0] {
        SPIKE = 2'b00,
        VSYN  = 2'b01,
        CFG   = 2'b10,
        RSVD  = 2'b11
    } aer_evt_type_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        CAPTURE = 2'b01,
        ACK     = 2'b10
    } aer_state_e;

    localparam int SYNC_STAGES = 2;
    localparam int ERR_CNT_W   = 8;

    function automatic logic is_reserved(input aer_evt_type_e t);
        return t == RSVD;
    endfunction

endpackage

// File: rtl/aer_rx_fifo.sv
// Event FIFO for the AER receiver: power-of-two depth, first-word-fall-through head.
module aer_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_en, pop_en;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    // Guard against overflow/underflow even if a caller misbehaves.
    assign push_en = push_i && !full_o;
    assign pop_en  = pop_i && !empty_o;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({push_en, pop_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the empty flag already hides stale contents.
    always_ff @(posedge CLK) begin
        if (push_en) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/aer_receiver.sv
// AER 4-phase handshake receiver: synchronizes REQ, captures events into a FIFO.
// Optional reserved-event error counter enabled by macro AER_RX_ERR_CNT_EN.
module aer_receiver
    import tinyodin_aer_pkg::*;
#(
    parameter int M     = 8,
    parameter int DEPTH = 4
) (
    input  logic         CLK,
    input  logic         RSTN,
    input  logic         enable_i,
    input  logic         AER_REQ_i,
    input  logic [M+1:0] AER_ADDR_i,
    output logic         AER_ACK_o,
    output logic         EVT_VALID_o,
    input  logic         EVT_READY_i,
    output logic [1:0]   EVT_TYPE_o,
    output logic [M-1:0] EVT_ADDR_o,
    output logic         busy_o
`ifdef AER_RX_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt_o
`endif
);

    aer_state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0]     sync_q, sync_d;
    logic                       ack_q, ack_d;
    logic                       req_s;
    logic                       push, pop;
    logic                       fifo_full, fifo_empty;
    logic                       rsvd;
    logic [M+1:0]               head;
    aer_evt_type_e              evt_type;

    assign req_s    = sync_q[SYNC_STAGES-1];
    assign evt_type = aer_evt_type_e'(AER_ADDR_i[M+1:M]);
    assign rsvd     = is_reserved(evt_type);

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], AER_REQ_i};
    end

    // Full is checked before leaving IDLE, so the CAPTURE push always has room.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_s && enable_i && !fifo_full) state_d = CAPTURE;
            end
            CAPTURE: begin
                push    = !rsvd;
                state_d = ACK;
            end
            ACK: begin
                if (!req_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ack_d = (state_d == ACK);
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
            sync_q  <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            ack_q   <= ack_d;
        end
    end

    assign AER_ACK_o   = ack_q;
    assign busy_o      = (state_q != IDLE);
    assign EVT_VALID_o = !fifo_empty;
    assign pop         = EVT_VALID_o && EVT_READY_i;
    assign EVT_TYPE_o  = head[M+1:M];
    assign EVT_ADDR_o  = head[M-1:0];

    aer_rx_fifo #(
        .WIDTH (M + 2),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .push_i  (push),
        .data_i  (AER_ADDR_i),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef AER_RX_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Saturate rather than wrap so a flood of reserved events stays visible.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (state_q == CAPTURE && rsvd && err_cnt_q != '1)
            err_cnt_d = err_cnt_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) err_cnt_q <= '0;
        else       err_cnt_q <= err_cnt_d;
    end

    assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_aer_receiver.sv
// Scoreboard bench for aer_receiver: directed handshakes, monitor checks popped events.
module tb_aer_receiver;

    localparam int M     = 8;
    localparam int DEPTH = 4;

    logic         CLK = 1'b0;
    logic         RSTN = 1'b0;
    logic         enable_i = 1'b0;
    logic         AER_REQ_i = 1'b0;
    logic [M+1:0] AER_ADDR_i = '0;
    logic         AER_ACK_o;
    logic         EVT_VALID_o;
    logic         EVT_READY_i = 1'b0;
    logic [1:0]   EVT_TYPE_o;
    logic [M-1:0] EVT_ADDR_o;
    logic         busy_o;
`ifdef AER_RX_ERR_CNT_EN
    logic [7:0]   err_cnt_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int n_popped = 0;
    logic [M+1:0] exp_q [$];

    always #5 CLK = ~CLK;

    aer_receiver #(.M(M), .DEPTH(DEPTH)) dut (
        .CLK         (CLK),
        .RSTN        (RSTN),
        .enable_i    (enable_i),
        .AER_REQ_i   (AER_REQ_i),
        .AER_ADDR_i  (AER_ADDR_i),
        .AER_ACK_o   (AER_ACK_o),
        .EVT_VALID_o (EVT_VALID_o),
        .EVT_READY_i (EVT_READY_i),
        .EVT_TYPE_o  (EVT_TYPE_o),
        .EVT_ADDR_o  (EVT_ADDR_o),
        .busy_o      (busy_o)
`ifdef AER_RX_ERR_CNT_EN
        ,
        .err_cnt_o   (err_cnt_o)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: samples mid-cycle, when the consumer handshake is about to complete.
    initial begin
        logic [M+1:0] e;
        forever begin
            @(negedge CLK);
            if (RSTN && EVT_VALID_o && EVT_READY_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", {22'd0, EVT_TYPE_o, EVT_ADDR_o}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("event_data", {22'd0, EVT_TYPE_o, EVT_ADDR_o}, {22'd0, e});
                    n_popped++;
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Counts edges until ACK reaches lvl; returns -1 if the bound expires.
    task automatic wait_ack(input logic lvl, input int max_edges, output int edges);
        edges = -1;
        for (int i = 1; i <= max_edges; i++) begin
            step();
            if (AER_ACK_o == lvl) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic handshake(input logic [M+1:0] a, input int exp_lat);
        int edges;
        if (a[M+1:M] != 2'b11) exp_q.push_back(a);
        AER_ADDR_i = a;
        AER_REQ_i  = 1'b1;
        wait_ack(1'b1, 40, edges);
        if (exp_lat > 0) check("ack_rise_latency", edges, exp_lat);
        else if (edges < 0) check("ack_rise_timeout", 0, 1);
        AER_REQ_i = 1'b0;
        wait_ack(1'b0, 40, edges);
        if (exp_lat > 0) check("ack_fall_latency", edges, 3);
        else if (edges < 0) check("ack_fall_timeout", 0, 1);
    endtask

    task automatic drain();
        EVT_READY_i = 1'b1;
        for (int i = 0; i < 50 && EVT_VALID_o; i++) step();
        step();
        check("drained_empty", EVT_VALID_o, 0);
        check("scoreboard_empty", exp_q.size(), 0);
    endtask

    initial begin
        int edges;
        int stalled;

        repeat (3) step();
        check("rst_ack", AER_ACK_o, 0);
        check("rst_valid", EVT_VALID_o, 0);
        check("rst_busy", busy_o, 0);
        RSTN = 1'b1;
        enable_i = 1'b1;
        step();

        // Single event, 4-edge latency, head visible while not consumed.
        handshake(10'h005, 4);
        check("single_valid", EVT_VALID_o, 1);
        check("single_type", EVT_TYPE_o, 2'b00);
        check("single_addr", EVT_ADDR_o, 8'h05);
        drain();

        // Fill the FIFO with the consumer stalled; 5th request must wait.
        EVT_READY_i = 1'b0;
        step();
        for (int i = 1; i <= 4; i++) handshake(10'(i), 4);
        exp_q.push_back(10'h005);
        AER_ADDR_i = 10'h005;
        AER_REQ_i  = 1'b1;
        stalled = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (AER_ACK_o || busy_o) stalled++;
        end
        check("full_stall_ack_low", stalled, 0);
        EVT_READY_i = 1'b1;
        step();
        EVT_READY_i = 1'b0;
        wait_ack(1'b1, 10, edges);
        check("after_pop_ack", edges > 0, 1);
        AER_REQ_i = 1'b0;
        wait_ack(1'b0, 10, edges);
        check("after_pop_ack_fall", edges, 3);
        drain();
        check("fill_popped", n_popped, 6);

        // Reserved type is acknowledged but never queued.
        EVT_READY_i = 1'b0;
        handshake(10'h3AA, 4);
        step();
        check("rsvd_not_queued", EVT_VALID_o, 0);
`ifdef AER_RX_ERR_CNT_EN
        check("rsvd_err_cnt", err_cnt_o, 1);
`endif

        // Reset while ACK is high drops ACK at once; held REQ restarts.
        AER_ADDR_i = 10'h107;
        AER_REQ_i  = 1'b1;
        wait_ack(1'b1, 10, edges);
        step();
        check("pre_rst_valid", EVT_VALID_o, 1);
        RSTN = 1'b0;
        #1;
        check("rst_mid_ack", AER_ACK_o, 0);
        check("rst_mid_valid", EVT_VALID_o, 0);
        step();
        RSTN = 1'b1;
        exp_q.push_back(10'h107);
        wait_ack(1'b1, 10, edges);
        check("rst_restart_latency", edges, 4);
        AER_REQ_i = 1'b0;
        wait_ack(1'b0, 10, edges);
        check("rst_restart_fall", edges, 3);
        drain();

        // Disabled receiver ignores REQ; enabling starts CAPTURE then ACK.
        enable_i   = 1'b0;
        AER_ADDR_i = 10'h0C3;
        AER_REQ_i  = 1'b1;
        stalled = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (AER_ACK_o) stalled++;
        end
        check("disabled_ack_low", stalled, 0);
        exp_q.push_back(10'h0C3);
        enable_i = 1'b1;
        wait_ack(1'b1, 10, edges);
        check("enable_latency", edges, 2);
        enable_i = 1'b0;
        step();
        check("enable_drop_keeps_ack", AER_ACK_o, 1);
        AER_REQ_i = 1'b0;
        wait_ack(1'b0, 10, edges);
        check("enable_drop_fall", edges, 3);
        enable_i = 1'b1;
        drain();

        // Streaming: 100 events with the consumer always ready.
        n_popped = 0;
        EVT_READY_i = 1'b1;
        for (int i = 0; i < 100; i++)
            handshake({2'(i % 3), 8'((i * 37 + 11) & 8'hFF)}, 4);
        drain();
        check("stream_count", n_popped, 100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
